// File: rtl/iir_sample_sequencer_if.sv
// Stream and filter-side signals of the IIR sample sequencer.
// master = sequencer side, slave = source/filter/sink side.
interface iir_sample_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic [WIDTH-1:0] f_xin;
    logic             f_en;
    logic [WIDTH-1:0] f_yout;
    logic             m_valid;
    logic [WIDTH-1:0] m_data;

    modport master (
        input  s_valid, s_data, f_yout,
        output s_ready, f_xin, f_en, m_valid, m_data
    );

    modport slave (
        output s_valid, s_data, f_yout,
        input  s_ready, f_xin, f_en, m_valid, m_data
    );
endinterface

// File: rtl/iir_sample_sequencer.sv
// Sample-rate sequencer for the IIR datapath: paces accepted samples to one per DIV
// clocks, captures filter results LAT cycles later, drops WARMUP outputs, flags done.
module iir_sample_sequencer #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DIV    = 4,
    parameter int unsigned LAT    = 1,
    parameter int unsigned WARMUP = 0,
    parameter int unsigned CNT_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic [CNT_W-1:0]      num_samples,
    iir_sample_sequencer_if.master bus,
    output logic [CNT_W-1:0]      count,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned       TICK_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(DIV - 1);
    localparam logic [CNT_W-1:0]  WARMUP_CNT = CNT_W'(WARMUP);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state, state_d;
    logic [TICK_W-1:0] tick, tick_d;
    logic [CNT_W-1:0]  target, target_d;
    logic [CNT_W-1:0]  count_d;
    logic [CNT_W-1:0]  out_cnt, out_cnt_d;
    logic [LAT-1:0]    tag_pipe, tag_d;
    logic              tag_out, hs, cap;
    logic              s_ready_d, f_en_d, m_valid_d, busy_d, done_d;
    logic [WIDTH-1:0]  f_xin_d, m_data_d;

    // Next-state and next-output decode; stop overrides every other transition.
    always_comb begin
        state_d   = state;
        tick_d    = tick;
        target_d  = target;
        count_d   = count;
        out_cnt_d = out_cnt;
        tag_d     = '0;

        tag_out   = tag_pipe[LAT-1];
        hs        = (state == RUN) && bus.s_ready && bus.s_valid && !stop;
        cap       = tag_out && !stop;

        f_en_d    = hs;
        f_xin_d   = hs ? bus.s_data : bus.f_xin;
        m_valid_d = cap && (out_cnt >= WARMUP_CNT);
        m_data_d  = cap ? bus.f_yout : bus.m_data;
        if (cap) begin
            out_cnt_d = out_cnt + CNT_W'(1);
        end

        if (!stop) begin
            tag_d[0] = bus.f_en;
            for (int i = 1; i < int'(LAT); i++) begin
                tag_d[i] = tag_pipe[i-1];
            end
        end

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    target_d  = num_samples;
                    count_d   = '0;
                    out_cnt_d = '0;
                    tick_d    = '0;
                    state_d   = (num_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (hs) begin
                    count_d = count + CNT_W'(1);
                    tick_d  = '0;
                    if (count_d == target) begin
                        state_d = DRAIN;
                    end
                end else if (tick != TICK_LAST) begin
                    tick_d = tick + TICK_W'(1);
                end
            end
            DRAIN: begin
                if (out_cnt == target) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (stop) begin
            state_d = IDLE;
            tick_d  = '0;
        end

        // Ready is registered, so it is derived from the next state and tick.
        s_ready_d = (state_d == RUN) && (tick_d == TICK_LAST);
        busy_d    = (state_d == RUN) || (state_d == DRAIN);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            tick        <= '0;
            target      <= '0;
            count       <= '0;
            out_cnt     <= '0;
            tag_pipe    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bus.s_ready <= 1'b0;
            bus.f_en    <= 1'b0;
            bus.f_xin   <= '0;
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
        end else begin
            state       <= state_d;
            tick        <= tick_d;
            target      <= target_d;
            count       <= count_d;
            out_cnt     <= out_cnt_d;
            tag_pipe    <= tag_d;
            busy        <= busy_d;
            done        <= done_d;
            bus.s_ready <= s_ready_d;
            bus.f_en    <= f_en_d;
            bus.f_xin   <= f_xin_d;
            bus.m_valid <= m_valid_d;
            bus.m_data  <= m_data_d;
        end
    end

endmodule

// File: tb/tb_iir_sample_sequencer.sv
// Bench for iir_sample_sequencer: two instances (WARMUP 0 and 2) share stimulus and are
// checked against a slot-timing model computed from the valid pattern.
module tb_iir_sample_sequencer;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 20;
    localparam int          DIV   = 4;
    localparam int          LAT   = 1;
    localparam int          WU    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start, stop;
    logic [CNT_W-1:0] num_samples;
    logic [CNT_W-1:0] count0, count1;
    logic             busy0, busy1, done0, done1;
    logic [31:0]      y0 = '0;
    logic [31:0]      y1 = '0;

    iir_sample_sequencer_if #(.WIDTH(WIDTH)) if0 ();
    iir_sample_sequencer_if #(.WIDTH(WIDTH)) if1 ();

    iir_sample_sequencer #(.WIDTH(WIDTH), .DIV(DIV), .LAT(LAT), .WARMUP(0), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .num_samples(num_samples),
        .bus(if0), .count(count0), .busy(busy0), .done(done0));

    iir_sample_sequencer #(.WIDTH(WIDTH), .DIV(DIV), .LAT(LAT), .WARMUP(WU), .CNT_W(CNT_W)) dut_wu (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .num_samples(num_samples),
        .bus(if1), .count(count1), .busy(busy1), .done(done1));

    always #5 clk = ~clk;

    // Stand-in filter: one-cycle latency, y = 3x + 7.
    always @(posedge clk) begin
        if (if0.f_en) y0 <= if0.f_xin * 32'd3 + 32'd7;
        if (if1.f_en) y1 <= if1.f_xin * 32'd3 + 32'd7;
    end
    assign if0.f_yout  = y0;
    assign if1.f_yout  = y1;
    assign if1.s_valid = if0.s_valid;
    assign if1.s_data  = if0.s_data;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          vpat [0:1023];
    logic [31:0] dat  [0:63];
    int          exp_fen[$];
    int          fen_c[$];
    logic [31:0] fen_x[$];
    int          mv0_c[$];
    logic [31:0] mv0_d[$];
    int          mv1_c[$];
    logic [31:0] mv1_d[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (if0.f_en)    begin fen_c.push_back(cyc); fen_x.push_back(if0.f_xin);  end
            if (if0.m_valid) begin mv0_c.push_back(cyc); mv0_d.push_back(if0.m_data); end
            if (if1.m_valid) begin mv1_c.push_back(cyc); mv1_d.push_back(if1.m_data); end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sample k issues one cycle after its slot handshake; a slot opens DIV-1 cycles
    // after the previous issue (first slot: DIV cycles after the start cycle).
    function automatic void build_model(input int s, input int n);
        int r;
        exp_fen.delete();
        r = s + DIV;
        for (int k = 0; k < n; k++) begin
            while (r - s < 1023 && !vpat[r - s]) r++;
            exp_fen.push_back(r + 1);
            r = r + DIV;
        end
    endfunction

    // Start a run from the valid pattern/data tables; ends on done or after budget cycles.
    task automatic run_seq(input int n, input int budget, input int stop_at,
                           output int s_cyc, output int done_at, output int rdy_lo, output int fx_chg);
        int          idx;
        bit          hs;
        logic [31:0] prev;
        idx = 0; rdy_lo = 0; fx_chg = 0; done_at = -1;
        @(posedge clk);
        fen_c.delete(); fen_x.delete(); mv0_c.delete(); mv0_d.delete(); mv1_c.delete(); mv1_d.delete();
        @(negedge clk);
        num_samples = CNT_W'(n);
        start       = 1'b1;
        if0.s_valid = 1'b0;
        s_cyc       = cyc;
        prev        = if0.f_xin;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < budget; c++) begin
            if (!if0.f_en && if0.f_xin !== prev) fx_chg++;
            prev = if0.f_xin;
            if (done0 === 1'b1) begin done_at = cyc; break; end
            stop        = (c == stop_at);
            if0.s_valid = vpat[c];
            if0.s_data  = dat[idx];
            hs          = vpat[c] && (if0.s_ready === 1'b1);
            if (!vpat[c] && if0.s_ready === 1'b1) rdy_lo++;
            @(negedge clk);
            if (hs && idx < 63) idx++;
        end
        stop        = 1'b0;
        if0.s_valid = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        if0.s_valid = 1'b1;
        if0.s_data  = 32'hdead_beef;
        repeat (3) @(negedge clk);
        total++;
        if ({if0.s_ready, if0.f_en, if0.m_valid, busy0, done0} !== 5'b0 ||
            if0.f_xin !== '0 || if0.m_data !== '0 || count0 !== '0) begin
            bad++;
            $display("FAIL reset_outputs got ready=%b fen=%b mv=%b busy=%b done=%b xin=%h md=%h cnt=%0d want all 0",
                     if0.s_ready, if0.f_en, if0.m_valid, busy0, done0, if0.f_xin, if0.m_data, count0);
        end
        total++;
        if ({if1.s_ready, if1.f_en, if1.m_valid, busy1, done1} !== 5'b0 || count1 !== '0) begin
            bad++;
            $display("FAIL reset_outputs_wu got nonzero control outputs want 0");
        end
        rst = 1'b1;
        repeat (10) @(negedge clk);
        total++;
        if (fen_c.size() != 0 || if0.s_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_no_fen got fen=%0d ready=%b want 0 0", fen_c.size(), if0.s_ready);
        end
        if0.s_valid = 1'b0;
    endtask

    task automatic test_basic();
        int s, d, rl, fc;
        for (int i = 0; i < 1024; i++) vpat[i] = 1'b1;
        dat[0] = 32'd10; dat[1] = 32'hffff_ffec; dat[2] = 32'd30;
        run_seq(3, 100, -1, s, d, rl, fc);
        total++;
        if (fen_c.size() != 3) begin bad++; $display("FAIL basic_fen_count got %0d want 3", fen_c.size()); end
        for (int k = 0; k < 3 && k < fen_c.size(); k++) begin
            total++;
            if (fen_c[k] !== s + 1 + DIV * (k + 1) || fen_x[k] !== dat[k]) begin
                bad++;
                $display("FAIL basic_fen%0d got cyc=%0d x=%h want cyc=%0d x=%h", k, fen_c[k] - s, fen_x[k], 1 + DIV * (k + 1), dat[k]);
            end
        end
        total++;
        if (mv0_c.size() != 3) begin bad++; $display("FAIL basic_mv_count got %0d want 3", mv0_c.size()); end
        for (int k = 0; k < 3 && k < mv0_c.size() && k < fen_c.size(); k++) begin
            total++;
            if (mv0_c[k] !== fen_c[k] + 2 || mv0_d[k] !== dat[k] * 32'd3 + 32'd7) begin
                bad++;
                $display("FAIL basic_mv%0d got dly=%0d d=%h want dly=2 d=%h", k, mv0_c[k] - fen_c[k], mv0_d[k], dat[k] * 32'd3 + 32'd7);
            end
        end
        total++;
        if (d !== s + 1 + DIV * 3 + 3 || count0 !== 20'd3 || busy0 !== 1'b0) begin
            bad++;
            $display("FAIL basic_done got at=%0d cnt=%0d busy=%b want at=%0d cnt=3 busy=0", d - s, count0, busy0, 1 + DIV * 3 + 3);
        end
        total++;
        if (mv1_c.size() != 1 || (mv1_d.size() > 0 && mv1_d[0] !== dat[2] * 32'd3 + 32'd7)) begin
            bad++;
            $display("FAIL basic_warmup_inst got %0d pulses want 1", mv1_c.size());
        end
    endtask

    task automatic test_stall();
        int s, d, rl, fc;
        for (int i = 0; i < 1024; i++) vpat[i] = (i < 8 || i > 14);
        dat[0] = $urandom; dat[1] = $urandom;
        run_seq(2, 100, -1, s, d, rl, fc);
        total++;
        if (rl != 7 || fc != 0) begin
            bad++;
            $display("FAIL stall_ready got ready_hold=%0d xin_changes=%0d want 7 0", rl, fc);
        end
        total++;
        if (fen_c.size() != 2 || fen_c[0] !== s + 5 || fen_c[1] !== s + 16 || fen_x[1] !== dat[1]) begin
            bad++;
            $display("FAIL stall_issue got n=%0d second=%0d want n=2 second=16", fen_c.size(),
                     fen_c.size() > 1 ? fen_c[1] - s : -1);
        end
        total++;
        if (d !== s + 19 || count0 !== 20'd2) begin
            bad++;
            $display("FAIL stall_done got at=%0d cnt=%0d want at=19 cnt=2", d - s, count0);
        end
    endtask

    task automatic test_warmup();
        int s, d, rl, fc;
        for (int i = 0; i < 1024; i++) vpat[i] = 1'b1;
        for (int i = 0; i < 5; i++) dat[i] = $urandom;
        run_seq(5, 100, -1, s, d, rl, fc);
        build_model(s, 5);
        total++;
        if (mv1_c.size() != 3 || mv0_c.size() != 5) begin
            bad++;
            $display("FAIL warmup_count got wu=%0d plain=%0d want 3 5", mv1_c.size(), mv0_c.size());
        end
        for (int k = 0; k < 3 && k < mv1_c.size(); k++) begin
            total++;
            if (mv1_c[k] !== exp_fen[k + WU] + LAT + 1 || mv1_d[k] !== dat[k + WU] * 32'd3 + 32'd7) begin
                bad++;
                $display("FAIL warmup_out%0d got cyc=%0d d=%h want cyc=%0d d=%h", k, mv1_c[k] - s, mv1_d[k],
                         exp_fen[k + WU] + LAT + 1 - s, dat[k + WU] * 32'd3 + 32'd7);
            end
        end
        total++;
        if (d !== exp_fen[4] + LAT + 2 || done1 !== 1'b1 || count1 !== 20'd5) begin
            bad++;
            $display("FAIL warmup_done got at=%0d done1=%b cnt1=%0d want at=%0d done1=1 cnt1=5",
                     d - s, done1, count1, exp_fen[4] + LAT + 2 - s);
        end
    endtask

    task automatic test_stop();
        int s, d, rl, fc;
        for (int i = 0; i < 1024; i++) vpat[i] = 1'b1;
        for (int i = 0; i < 4; i++) dat[i] = $urandom;
        run_seq(4, 40, 2 * DIV, s, d, rl, fc);
        total++;
        if (count0 !== 20'd1 || done0 !== 1'b0 || busy0 !== 1'b0 || if0.s_ready !== 1'b0 || d != -1) begin
            bad++;
            $display("FAIL stop_state got cnt=%0d done=%b busy=%b ready=%b want 1 0 0 0", count0, done0, busy0, if0.s_ready);
        end
        total++;
        if (fen_c.size() != 1 || mv0_c.size() != 1 || mv1_c.size() != 0) begin
            bad++;
            $display("FAIL stop_no_output got fen=%0d mv=%0d want 1 1", fen_c.size(), mv0_c.size());
        end
    endtask

    task automatic test_zero();
        int s, d, rl, fc;
        for (int i = 0; i < 1024; i++) vpat[i] = 1'b1;
        run_seq(0, 20, -1, s, d, rl, fc);
        total++;
        if (d !== s + 1 || fen_c.size() != 0 || count0 !== '0) begin
            bad++;
            $display("FAIL zero_run got at=%0d fen=%0d cnt=%0d want at=1 fen=0 cnt=0", d - s, fen_c.size(), count0);
        end
        dat[0] = $urandom;
        run_seq(1, 40, -1, s, d, rl, fc);
        total++;
        if (fen_c.size() != 1 || fen_x[0] !== dat[0] || d !== s + DIV + 1 + LAT + 2 ||
            count0 !== 20'd1 || mv1_c.size() != 0 || done1 !== 1'b1) begin
            bad++;
            $display("FAIL single_run got fen=%0d at=%0d cnt=%0d wu_mv=%0d want fen=1 at=%0d cnt=1 wu_mv=0",
                     fen_c.size(), d - s, count0, mv1_c.size(), DIV + 1 + LAT + 2);
        end
    endtask

    task automatic test_random();
        int s, d, rl, fc, n;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 12);
            for (int i = 0; i < 1024; i++) vpat[i] = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 64; i++) dat[i] = $urandom;
            run_seq(n, 600, -1, s, d, rl, fc);
            build_model(s, n);
            total++;
            if (fen_c.size() != n || mv0_c.size() != n || mv1_c.size() != (n > WU ? n - WU : 0) || fc != 0) begin
                bad++;
                $display("FAIL rand%0d_counts got fen=%0d mv=%0d wu=%0d xchg=%0d want n=%0d", it,
                         fen_c.size(), mv0_c.size(), mv1_c.size(), fc, n);
            end
            for (int k = 0; k < n && k < fen_c.size() && k < mv0_c.size(); k++) begin
                total++;
                if (fen_c[k] !== exp_fen[k] || fen_x[k] !== dat[k] ||
                    mv0_c[k] !== exp_fen[k] + LAT + 1 || mv0_d[k] !== dat[k] * 32'd3 + 32'd7) begin
                    bad++;
                    $display("FAIL rand%0d_s%0d got fen=%0d x=%h mv=%0d d=%h want fen=%0d x=%h", it, k,
                             fen_c[k] - s, fen_x[k], mv0_c[k] - s, mv0_d[k], exp_fen[k] - s, dat[k]);
                end
            end
            total++;
            if (d !== exp_fen[n - 1] + LAT + 2 || count0 !== CNT_W'(n)) begin
                bad++;
                $display("FAIL rand%0d_done got at=%0d cnt=%0d want at=%0d cnt=%0d", it, d - s, count0,
                         exp_fen[n - 1] + LAT + 2 - s, n);
            end
        end
    endtask

    initial begin
        start       = 1'b0;
        stop        = 1'b0;
        num_samples = '0;
        if0.s_valid = 1'b0;
        if0.s_data  = '0;
        #2 rst = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_warmup();
        test_stop();
        test_zero();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
